lane_bitslip: RTL and testbench
===============================

LANE_BITSLIP -- requirements
Module: lane_bitslip

Interface
REQ-001 SHALL have parameter LANES, default 1, meaning the number of independent DDR lanes (LANES >= 1).
REQ-002 SHALL have port dco_clk  input  1  DDR data clock; posedge and negedge both used; the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port bit_rise  input  LANES  per-lane bit sampled on the dco_clk rising edge.
REQ-005 SHALL have port bit_fall  input  LANES  per-lane bit sampled on the dco_clk falling edge.
REQ-006 SHALL have port bitslip_pulse  input  LANES  per-lane request to toggle the slip state, sampled on posedge.
REQ-007 SHALL have port out_rise  output  LANES  registered rise-slot output, updated on posedge.
REQ-008 SHALL have port out_fall  output  LANES  registered fall-slot output, updated on negedge.

Function
REQ-009 SHALL keep a per-lane slip flag, a rise_hold register and a fall_hold register; lanes SHALL be fully independent.
REQ-010 SHALL on each posedge capture rise_hold <= bit_rise.
REQ-011 SHALL on each negedge capture fall_hold <= bit_fall.
REQ-012 SHALL on each posedge set slip <= slip XOR bitslip_pulse, so a pulse held high for N posedges toggles N times.
REQ-013 SHALL on each posedge set out_rise <= bit_rise when slip = 0, and out_rise <= fall_hold when slip = 1.
REQ-014 SHALL use the pre-toggle slip value for out_rise on the posedge where the toggle occurs.
REQ-015 SHALL on each negedge set out_fall <= bit_fall when slip = 0, and out_fall <= rise_hold when slip = 1.
REQ-016 SHALL use the slip value updated on the preceding posedge for out_fall, so a slip takes effect on out_fall half a cycle after the toggle edge.
REQ-017 SHALL in slip = 1 produce a one-half-cycle shift of the DDR stream: out_rise = bit_fall of the previous cycle, and out_fall = bit_rise of the current cycle.
REQ-018 SHALL have a latency of one half-cycle in slip = 0: out_rise is the current posedge's bit_rise and out_fall is the current negedge's bit_fall.
REQ-019 SHALL return to pass-through on a second toggle, with the same edge ordering as REQ-014 and REQ-016.
REQ-020 SHALL contain no combinational path from inputs to outputs.

Reset
REQ-021 SHALL, while rst_n = 0, asynchronously clear slip, rise_hold, fall_hold, out_rise and out_fall to 0 in all lanes.
REQ-022 SHALL resume on the first posedge after deassertion with slip = 0 (pass-through), and fall_hold = 0 until the first negedge.
REQ-023 SHALL, on reset asserted mid-operation, immediately zero the outputs and discard any pending slip state.

Verification
REQ-024 SHALL pass: reset for 2 cycles then release -> out_rise = out_fall = 0 before the first edges; slip = 0.
REQ-025 SHALL pass: pass-through, with bit_rise = k[0] and bit_fall = ~k[0] for k = 0..3 -> 1 ps after each posedge out_rise = bit_rise, and 1 ps after each negedge out_fall = bit_fall.
REQ-026 SHALL pass: bitslip_pulse = 1 for one posedge with k = 4 (rise = 0, fall = 1) -> out_rise = 0 at that posedge (old slip); at the next negedge out_fall = 0 (rise_hold).
REQ-027 SHALL pass: continuing slipped with k = 5 (rise = 1, fall = 0) -> posedge out_rise = 1 (previous fall); negedge out_fall = 1 (current rise).
REQ-028 SHALL pass: a second single-cycle pulse -> pass-through restored, out_fall = bit_fall from the following negedge.
REQ-029 SHALL pass: LANES = 4 with a pulse on lane 2 only -> only lane 2 shifts; lanes 0, 1 and 3 stay pass-through.

Source files
------------

// File: rtl/lane_bitslip.sv
`timescale 1ns/1ps
// Per-lane DDR bitslip: optionally delays the rise/fall stream by one half-cycle
// so that a receiver can realign which edge carries the even bit.
module lane_bitslip #(
  parameter int LANES = 1
) (
  input  logic             dco_clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] bit_rise,
  input  logic [LANES-1:0] bit_fall,
  input  logic [LANES-1:0] bitslip_pulse,
  output logic [LANES-1:0] out_rise,
  output logic [LANES-1:0] out_fall
);

  logic [LANES-1:0] r_slip;
  logic [LANES-1:0] r_rise_hold;
  logic [LANES-1:0] r_fall_hold;
  logic [LANES-1:0] r_out_rise;
  logic [LANES-1:0] r_out_fall;
  logic [LANES-1:0] w_rise_sel;
  logic [LANES-1:0] w_fall_sel;

  // Slipped lanes take the bit from the opposite edge, one half-cycle older.
  assign w_rise_sel = (bit_rise & ~r_slip) | (r_fall_hold & r_slip);
  assign w_fall_sel = (bit_fall & ~r_slip) | (r_rise_hold & r_slip);

  // Rise domain: the mux above still sees the pre-toggle slip on this edge.
  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slip      <= '0;
      r_rise_hold <= '0;
      r_out_rise  <= '0;
    end else begin
      r_slip      <= r_slip ^ bitslip_pulse;
      r_rise_hold <= bit_rise;
      r_out_rise  <= w_rise_sel;
    end
  end

  // Fall domain: sees the slip value written on the preceding posedge.
  always_ff @(negedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fall_hold <= '0;
      r_out_fall  <= '0;
    end else begin
      r_fall_hold <= bit_fall;
      r_out_fall  <= w_fall_sel;
    end
  end

  assign out_rise = r_out_rise;
  assign out_fall = r_out_fall;

endmodule

// File: tb/tb_lane_bitslip.sv
`timescale 1ns/1ps
// Bench for lane_bitslip (4 lanes): directed vector table, async-reset corners,
// and random traffic checked against a half-slot stream model.
module tb_lane_bitslip;
  localparam int L = 4;
  localparam int HMAX = 4096;

  logic         dco_clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [L-1:0] bit_rise = '0;
  logic [L-1:0] bit_fall = '0;
  logic [L-1:0] bitslip_pulse = '0;
  logic [L-1:0] out_rise;
  logic [L-1:0] out_fall;

  int n_chk = 0;
  int n_err = 0;

  lane_bitslip #(.LANES(L)) dut (
    .dco_clk      (dco_clk),
    .rst_n        (rst_n),
    .bit_rise     (bit_rise),
    .bit_fall     (bit_fall),
    .bitslip_pulse(bitslip_pulse),
    .out_rise     (out_rise),
    .out_fall     (out_fall)
  );

  always #5 dco_clk = ~dco_clk;

  // Reference: the input DDR stream as a flat list of half-slots
  // (rise0, fall0, rise1, ...). Slipped output at slot n is stream[n-1].
  logic hist [L][HMAX];
  int   nh;
  int   npulse [L];

  task automatic model_reset();
    nh = 0;
    for (int l = 0; l < L; l++) npulse[l] = 0;
  endtask

  task automatic chk(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One full clock cycle, entered between a negedge and the next posedge.
  task automatic run_cycle(input logic [L-1:0] r, input logic [L-1:0] f, input logic [L-1:0] p,
                           output logic [L-1:0] ar, output logic [L-1:0] er,
                           output logic [L-1:0] af, output logic [L-1:0] ef);
    bit_rise      = r;
    bit_fall      = f;
    bitslip_pulse = p;
    @(posedge dco_clk);
    #1ps;
    ar = out_rise;
    for (int l = 0; l < L; l++) begin
      hist[l][nh] = r[l];
      if (npulse[l] % 2 == 1) er[l] = (nh > 0) ? hist[l][nh-1] : 1'b0;
      else                    er[l] = r[l];
      npulse[l] += int'(p[l]);
    end
    nh++;
    bitslip_pulse = '0;
    @(negedge dco_clk);
    #1ps;
    af = out_fall;
    for (int l = 0; l < L; l++) begin
      hist[l][nh] = f[l];
      if (npulse[l] % 2 == 1) ef[l] = hist[l][nh-1];
      else                    ef[l] = f[l];
    end
    nh++;
  endtask

  typedef struct {
    logic [L-1:0] r;
    logic [L-1:0] f;
    logic [L-1:0] p;
    logic [L-1:0] er;
    logic [L-1:0] ef;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [L-1:0] ar, er, af, ef;
    logic [L-1:0] r, f, p;

    // Pass-through k=0..3, slip/unslip all lanes, then lane 2 only.
    tbl[0]  = '{4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
    tbl[1]  = '{4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
    tbl[2]  = '{4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
    tbl[3]  = '{4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
    tbl[4]  = '{4'h0, 4'hF, 4'hF, 4'h0, 4'h0};
    tbl[5]  = '{4'hF, 4'h0, 4'h0, 4'hF, 4'hF};
    tbl[6]  = '{4'h0, 4'hF, 4'hF, 4'h0, 4'hF};
    tbl[7]  = '{4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
    tbl[8]  = '{4'h0, 4'hF, 4'h4, 4'h0, 4'hB};
    tbl[9]  = '{4'hF, 4'h0, 4'h0, 4'hF, 4'h4};
    tbl[10] = '{4'hF, 4'hF, 4'h0, 4'hB, 4'hF};
    tbl[11] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h0};

    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge dco_clk);
    #1ps;
    chk("reset_out_rise", out_rise, '0);
    chk("reset_out_fall", out_fall, '0);
    @(negedge dco_clk);
    #2 rst_n = 1'b1;
    #1ps;
    chk("release_out_rise", out_rise, '0);
    chk("release_out_fall", out_fall, '0);

    for (int i = 0; i < 12; i++) begin
      run_cycle(tbl[i].r, tbl[i].f, tbl[i].p, ar, er, af, ef);
      chk($sformatf("vec%0d_rise", i), ar, tbl[i].er);
      chk($sformatf("vec%0d_fall", i), af, tbl[i].ef);
    end

    // Pulse held for three posedges on lanes 0/1 toggles three times (ends slipped).
    for (int i = 0; i < 5; i++) begin
      p = (i < 3) ? 4'h3 : 4'h0;
      run_cycle(4'(i * 5), 4'(~(i * 3)), p, ar, er, af, ef);
      chk($sformatf("held%0d_rise", i), ar, er);
      chk($sformatf("held%0d_fall", i), af, ef);
    end

    for (int i = 0; i < 300; i++) begin
      r = 4'($urandom);
      f = 4'($urandom);
      p = 4'($urandom) & 4'($urandom);
      run_cycle(r, f, p, ar, er, af, ef);
      chk($sformatf("rnd%0d_rise", i), ar, er);
      chk($sformatf("rnd%0d_fall", i), af, ef);
    end

    // Mid-operation reset with some lanes slipped and outputs driven high.
    run_cycle(4'hF, 4'hF, 4'h5, ar, er, af, ef);
    chk("pre_rst_rise", ar, er);
    chk("pre_rst_fall", af, ef);
    run_cycle(4'hF, 4'hF, 4'h0, ar, er, af, ef);
    chk("pre_rst_rise_hi", ar, 4'hF);
    chk("pre_rst_fall_hi", af, 4'hF);
    #2 rst_n = 1'b0;
    #1ps;
    chk("async_rst_rise", out_rise, '0);
    chk("async_rst_fall", out_fall, '0);
    bit_rise = 4'hF;
    bit_fall = 4'hF;
    bitslip_pulse = 4'hF;
    #20;
    chk("held_rst_rise", out_rise, '0);
    chk("held_rst_fall", out_fall, '0);
    bitslip_pulse = '0;
    rst_n = 1'b1;
    model_reset();

    // Slip state discarded: pass-through on every lane straight after release.
    run_cycle(4'hA, 4'h5, 4'h0, ar, er, af, ef);
    chk("post_rst_rise", ar, 4'hA);
    chk("post_rst_fall", af, 4'h5);
    for (int i = 0; i < 20; i++) begin
      r = 4'($urandom);
      f = 4'($urandom);
      p = 4'($urandom) & 4'($urandom);
      run_cycle(r, f, p, ar, er, af, ef);
      chk($sformatf("post%0d_rise", i), ar, er);
      chk($sformatf("post%0d_fall", i), af, ef);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
